// File: rtl/alu_input_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : alu_input_sequencer
// Description : Front-end controller for the board ALU. One shared switch
//               bank loads operand A, operand B and the operation code in
//               turn. A debounced "next" button steps the sequence, and a
//               debounced "clear" button restarts it. Once all three values
//               are loaded, the ALU result is registered onto the LEDs.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_input_sequencer #(
    parameter int NB_DATA         = 4,
    parameter int NB_OP           = 6,
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic               clk,
    input  logic               i_reset,
    input  logic [NB_OP-1:0]   i_sw,
    input  logic               i_btn_next,
    input  logic               i_btn_clear,
    input  logic [NB_DATA-1:0] i_alu_result,
    output logic [NB_DATA-1:0] o_datoA,
    output logic [NB_DATA-1:0] o_datoB,
    output logic [NB_OP-1:0]   o_operation,
    output logic [NB_DATA-1:0] o_leds,
    output logic [1:0]         o_state,
    output logic               o_result_valid
);

    // Counter only needs to hold 0 .. DEBOUNCE_CYCLES-1; the flip happens
    // on the cycle that would have taken it to DEBOUNCE_CYCLES.
    localparam int C_CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [C_CNT_W-1:0] C_CNT_LAST = C_CNT_W'(DEBOUNCE_CYCLES - 1);

    // Button index 0 = next, 1 = clear.
    localparam int C_NUM_BTN = 2;

    typedef enum logic [1:0] {
        WAIT_A  = 2'b00,
        WAIT_B  = 2'b01,
        WAIT_OP = 2'b10,
        SHOW    = 2'b11
    } state_t;

    logic [C_NUM_BTN-1:0] btn_raw_w;
    logic [C_NUM_BTN-1:0] btn_pulse_w;

    assign btn_raw_w = {i_btn_clear, i_btn_next};

    // ------------------------------------------------------------------------
    // Per-button conditioning: 2-flop synchronizer, counter debouncer and a
    // rising-edge detector on the debounced level (presses only).
    // ------------------------------------------------------------------------
    generate
        for (genvar g = 0; g < C_NUM_BTN; g++) begin : g_btn
            logic               sync1_q;
            logic               sync2_q;
            logic               deb_q;
            logic               deb_dly_q;
            logic [C_CNT_W-1:0] cnt_q;

            // Synchronize, debounce and delay the debounced level by one cycle.
            always_ff @(posedge clk or posedge i_reset) begin
                if (i_reset) begin
                    sync1_q   <= 1'b0;
                    sync2_q   <= 1'b0;
                    deb_q     <= 1'b0;
                    deb_dly_q <= 1'b0;
                    cnt_q     <= '0;
                end else begin
                    sync1_q   <= btn_raw_w[g];
                    sync2_q   <= sync1_q;
                    deb_dly_q <= deb_q;
                    if (sync2_q != deb_q) begin
                        if (cnt_q == C_CNT_LAST) begin
                            deb_q <= sync2_q;
                            cnt_q <= '0;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end else begin
                        cnt_q <= '0;
                    end
                end
            end

            assign btn_pulse_w[g] = deb_q & ~deb_dly_q;
        end
    endgenerate

    logic next_pulse_w;
    logic clear_pulse_w;

    assign next_pulse_w  = btn_pulse_w[0];
    assign clear_pulse_w = btn_pulse_w[1];

    // ------------------------------------------------------------------------
    // Sequencer FSM and the operand / operation / LED registers.
    // ------------------------------------------------------------------------
    state_t             state_q, state_d;
    logic [NB_DATA-1:0] dato_a_q, dato_a_d;
    logic [NB_DATA-1:0] dato_b_q, dato_b_d;
    logic [NB_OP-1:0]   op_q, op_d;
    logic [NB_DATA-1:0] leds_q, leds_d;

    // State and data registers; reset aborts any partial sequence.
    always_ff @(posedge clk or posedge i_reset) begin
        if (i_reset) begin
            state_q  <= WAIT_A;
            dato_a_q <= '0;
            dato_b_q <= '0;
            op_q     <= '0;
            leds_q   <= '0;
        end else begin
            state_q  <= state_d;
            dato_a_q <= dato_a_d;
            dato_b_q <= dato_b_d;
            op_q     <= op_d;
            leds_q   <= leds_d;
        end
    end

    // Next-state and capture logic; clear has priority over next.
    always_comb begin
        state_d  = state_q;
        dato_a_d = dato_a_q;
        dato_b_d = dato_b_q;
        op_d     = op_q;
        leds_d   = leds_q;

        // The ALU only sees registered inputs, so its result is stable here.
        if (state_q == SHOW) begin
            leds_d = i_alu_result;
        end

        if (clear_pulse_w) begin
            state_d  = WAIT_A;
            dato_a_d = '0;
            dato_b_d = '0;
            op_d     = '0;
            leds_d   = '0;
        end else if (next_pulse_w) begin
            case (state_q)
                WAIT_A: begin
                    dato_a_d = i_sw[NB_DATA-1:0];
                    state_d  = WAIT_B;
                end
                WAIT_B: begin
                    dato_b_d = i_sw[NB_DATA-1:0];
                    state_d  = WAIT_OP;
                end
                WAIT_OP: begin
                    op_d    = i_sw;
                    state_d = SHOW;
                end
                default: begin
                    state_d = WAIT_A;
                end
            endcase
        end
    end

    assign o_datoA        = dato_a_q;
    assign o_datoB        = dato_b_q;
    assign o_operation    = op_q;
    assign o_leds         = leds_q;
    assign o_state        = state_q;
    assign o_result_valid = (state_q == SHOW);

endmodule
`default_nettype wire

// File: tb/tb_alu_input_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_input_sequencer
// Description : Scoreboard bench for alu_input_sequencer with a stub ALU
//               returning A+B. Stimulus queues the expected register
//               snapshot for every state change. A negedge monitor pops and
//               compares that snapshot whenever o_state moves.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_input_sequencer;

    localparam int C_NB_DATA = 4;
    localparam int C_NB_OP   = 6;
    localparam int C_DEB     = 4;

    logic                 clk;
    logic                 i_reset;
    logic [C_NB_OP-1:0]   i_sw;
    logic                 i_btn_next;
    logic                 i_btn_clear;
    logic [C_NB_DATA-1:0] i_alu_result;
    logic [C_NB_DATA-1:0] o_datoA;
    logic [C_NB_DATA-1:0] o_datoB;
    logic [C_NB_OP-1:0]   o_operation;
    logic [C_NB_DATA-1:0] o_leds;
    logic [1:0]           o_state;
    logic                 o_result_valid;

    alu_input_sequencer #(
        .NB_DATA        (C_NB_DATA),
        .NB_OP          (C_NB_OP),
        .DEBOUNCE_CYCLES(C_DEB)
    ) dut (
        .clk           (clk),
        .i_reset       (i_reset),
        .i_sw          (i_sw),
        .i_btn_next    (i_btn_next),
        .i_btn_clear   (i_btn_clear),
        .i_alu_result  (i_alu_result),
        .o_datoA       (o_datoA),
        .o_datoB       (o_datoB),
        .o_operation   (o_operation),
        .o_leds        (o_leds),
        .o_state       (o_state),
        .o_result_valid(o_result_valid)
    );

    // Stub ALU: 4-bit sum of the registered operands.
    assign i_alu_result = o_datoA + o_datoB;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]           state;
        logic [C_NB_DATA-1:0] a;
        logic [C_NB_DATA-1:0] b;
        logic [C_NB_OP-1:0]   op;
        logic [C_NB_DATA-1:0] leds;
    } snap_t;

    snap_t exp_q[$];
    int    n_tests = 0;
    int    n_fail  = 0;
    int    n_trans = 0;
    logic [1:0] prev_state = 2'b00;

    task automatic check(input string name, input int actual, input int expected);
        n_tests++;
        if (actual != expected) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic push(input logic [1:0] st, input logic [3:0] a, input logic [3:0] b,
                        input logic [5:0] op, input logic [3:0] leds);
        snap_t s;
        s.state = st;
        s.a     = a;
        s.b     = b;
        s.op    = op;
        s.leds  = leds;
        exp_q.push_back(s);
    endtask

    // Monitor: every change of o_state is one DUT output event to score.
    always @(negedge clk) begin
        if (o_state !== prev_state) begin
            snap_t e;
            n_trans++;
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_transition: state %b -> %b", prev_state, o_state);
            end else begin
                e = exp_q.pop_front();
                check("sb_state", int'(o_state), int'(e.state));
                check("sb_datoA", int'(o_datoA), int'(e.a));
                check("sb_datoB", int'(o_datoB), int'(e.b));
                check("sb_operation", int'(o_operation), int'(e.op));
                check("sb_leds", int'(o_leds), int'(e.leds));
            end
            prev_state = o_state;
        end
    end

    // Raise the selected raw buttons just after an edge and hold them until
    // the state moves. The FSM must act 6 edges after the first sampling edge.
    task automatic press(input logic nxt, input logic clr, input logic [5:0] sw);
        logic [1:0] start;
        int         n;
        bit         moved;
        @(posedge clk);
        #1;
        i_sw        = sw;
        start       = o_state;
        i_btn_next  = nxt;
        i_btn_clear = clr;
        n           = 0;
        moved       = 1'b0;
        while (!moved && n < 30) begin
            @(posedge clk);
            #1;
            n++;
            if (o_state != start) moved = 1'b1;
        end
        if (!moved) begin
            n_tests++;
            n_fail++;
            $display("FAIL press_timeout: state stuck at %b after %0d edges", o_state, n);
        end else begin
            check("press_latency", n - 1, C_DEB + 2);
        end
        i_btn_next  = 1'b0;
        i_btn_clear = 1'b0;
        repeat (12) @(posedge clk);
    endtask

    initial begin
        int t0;
        i_reset     = 1'b1;
        i_sw        = '0;
        i_btn_next  = 1'b0;
        i_btn_clear = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_state", int'(o_state), 0);
        check("rst_valid", int'(o_result_valid), 0);
        check("rst_datoA", int'(o_datoA), 0);
        check("rst_leds", int'(o_leds), 0);
        i_reset = 1'b0;
        repeat (2) @(posedge clk);

        // Full sequence: 3, 5, op 0x20 -> leds 8 one cycle after SHOW.
        push(2'b01, 4'h3, 4'h0, 6'h00, 4'h0);
        press(1'b1, 1'b0, 6'h03);
        push(2'b10, 4'h3, 4'h5, 6'h00, 4'h0);
        press(1'b1, 1'b0, 6'h05);
        push(2'b11, 4'h3, 4'h5, 6'h20, 4'h0);
        press(1'b1, 1'b0, 6'h20);
        check("show_valid", int'(o_result_valid), 1);
        check("show_leds", int'(o_leds), 8);

        // Wrap: SHOW -> WAIT_A keeps everything, then recapture A = F.
        push(2'b00, 4'h3, 4'h5, 6'h20, 4'h8);
        press(1'b1, 1'b0, 6'h0C);
        check("wrap_valid", int'(o_result_valid), 0);
        push(2'b01, 4'hF, 4'h5, 6'h20, 4'h8);
        press(1'b1, 1'b0, 6'h0F);
        push(2'b10, 4'hF, 4'h9, 6'h20, 4'h8);
        press(1'b1, 1'b0, 6'h09);
        push(2'b11, 4'hF, 4'h9, 6'h3F, 4'h8);
        press(1'b1, 1'b0, 6'h3F);
        check("wrap_show_leds", int'(o_leds), 8);

        // Clear from SHOW.
        push(2'b00, 4'h0, 4'h0, 6'h00, 4'h0);
        press(1'b0, 1'b1, 6'h15);

        // Glitch: three raw cycles high must not move the FSM.
        t0 = n_trans;
        @(posedge clk);
        #1;
        i_btn_next = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        i_btn_next = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        check("glitch_state", int'(o_state), 0);
        check("glitch_trans", n_trans - t0, 0);

        // Held for 200 cycles: exactly one transition.
        t0 = n_trans;
        push(2'b01, 4'h7, 4'h0, 6'h00, 4'h0);
        i_sw = 6'h07;
        @(posedge clk);
        #1;
        i_btn_next = 1'b1;
        repeat (200) @(posedge clk);
        #1;
        i_btn_next = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        check("held_state", int'(o_state), 1);
        check("held_trans", n_trans - t0, 1);

        // Clear and next together from WAIT_B: clear wins.
        t0 = n_trans;
        push(2'b00, 4'h0, 4'h0, 6'h00, 4'h0);
        press(1'b1, 1'b1, 6'h0A);
        check("both_trans", n_trans - t0, 1);

        // Reset mid-sequence in WAIT_OP: outputs clear asynchronously.
        push(2'b01, 4'h4, 4'h0, 6'h00, 4'h0);
        press(1'b1, 1'b0, 6'h04);
        push(2'b10, 4'h4, 4'h6, 6'h00, 4'h0);
        press(1'b1, 1'b0, 6'h06);
        push(2'b00, 4'h0, 4'h0, 6'h00, 4'h0);
        @(posedge clk);
        #2;
        i_reset = 1'b1;
        #1;
        check("arst_datoA", int'(o_datoA), 0);
        check("arst_datoB", int'(o_datoB), 0);
        check("arst_op", int'(o_operation), 0);
        check("arst_leds", int'(o_leds), 0);
        repeat (2) @(posedge clk);
        #1;
        i_reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("arst_state_after", int'(o_state), 0);

        repeat (2) @(posedge clk);
        check("sb_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
